// File: rtl/score_access_arbiter.sv
// Round-robin arbiter that shares one score tracker between NUM_REQ requesters.
// Optional WAIT-state timeout is enabled by defining SCORE_ARB_TIMEOUT_EN.
module score_access_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned SCORE_W = 7,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*ID_W-1:0]    req_id_i,
  input  logic [NUM_REQ*SCORE_W-1:0] req_score_i,
  input  logic [NUM_REQ-1:0]         req_guest_i,
  output logic                       trk_req_o,
  output logic [ID_W-1:0]            trk_id_o,
  output logic [SCORE_W-1:0]         trk_score_o,
  output logic                       trk_guest_o,
  input  logic                       trk_valid_i,
  input  logic                       trk_pwin_i,
  input  logic                       trk_gwin_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic                       rsp_pwin_o,
  output logic                       rsp_gwin_o,
  output logic                       rsp_timeout_o,
  output logic                       busy_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]                      state_q, state_d;
  logic [NUM_REQ-1:0]              pend_q, pend_d;
  logic [NUM_REQ-1:0][ID_W-1:0]    hid_q, hid_d;
  logic [NUM_REQ-1:0][SCORE_W-1:0] hscore_q, hscore_d;
  logic [NUM_REQ-1:0]              hguest_q, hguest_d;
  logic [IdxW-1:0]                 ptr_q, ptr_d;
  logic [IdxW-1:0]                 win_q, win_d;
  logic [NUM_REQ-1:0]              grant_q, grant_d;
  logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
  logic                            rsp_pwin_q, rsp_pwin_d;
  logic                            rsp_gwin_q, rsp_gwin_d;
  logic                            trk_req_q, trk_req_d;
  logic [ID_W-1:0]                 trk_id_q, trk_id_d;
  logic [SCORE_W-1:0]              trk_score_q, trk_score_d;
  logic                            trk_guest_q, trk_guest_d;

  logic                            any_pend;
  logic [IdxW-1:0]                 pick;
  logic [IdxW-1:0]                 cand;

`ifdef SCORE_ARB_TIMEOUT_EN
  localparam logic [3:0] TimeoutLast = 4'(TIMEOUT - 1);
  logic [3:0] cnt_q, cnt_d;
  logic       rsp_timeout_q, rsp_timeout_d;
`endif

  // First pending requester at or after ptr_q, ascending with wrap.
  always_comb begin
    pick     = '0;
    cand     = '0;
    any_pend = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IdxW'((32'(ptr_q) + off) % NUM_REQ);
      if (!any_pend && pend_q[cand]) begin
        any_pend = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    pend_d      = pend_q;
    hid_d       = hid_q;
    hscore_d    = hscore_q;
    hguest_d    = hguest_q;
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    grant_d     = grant_q;
    rsp_valid_d = rsp_valid_q;
    rsp_pwin_d  = rsp_pwin_q;
    rsp_gwin_d  = rsp_gwin_q;
    trk_req_d   = 1'b0;
    trk_id_d    = trk_id_q;
    trk_score_d = trk_score_q;
    trk_guest_d = trk_guest_q;
`ifdef SCORE_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    // A request already pending keeps its first data.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_i[i] && !pend_q[i]) begin
        pend_d[i]   = 1'b1;
        hid_d[i]    = req_id_i[i*ID_W +: ID_W];
        hscore_d[i] = req_score_i[i*SCORE_W +: SCORE_W];
        hguest_d[i] = req_guest_i[i];
      end
    end

    case (state_q)
      StIdle: begin
        if (any_pend) begin
          win_d         = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          trk_id_d      = hid_q[pick];
          trk_score_d   = hscore_q[pick];
          trk_guest_d   = hguest_q[pick];
          pend_d[pick]  = 1'b0;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        trk_req_d = 1'b1;
`ifdef SCORE_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
        state_d   = StWait;
      end
      StWait: begin
        if (trk_valid_i) begin
          rsp_valid_d   = grant_q;
          rsp_pwin_d    = trk_pwin_i;
          rsp_gwin_d    = trk_gwin_i;
`ifdef SCORE_ARB_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d       = StDone;
        end
`ifdef SCORE_ARB_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          rsp_valid_d   = grant_q;
          rsp_pwin_d    = 1'b0;
          rsp_gwin_d    = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      StDone: begin
        rsp_valid_d   = '0;
        rsp_pwin_d    = 1'b0;
        rsp_gwin_d    = 1'b0;
`ifdef SCORE_ARB_TIMEOUT_EN
        rsp_timeout_d = 1'b0;
`endif
        grant_d       = '0;
        ptr_d         = IdxW'((32'(win_q) + 1) % NUM_REQ);
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      pend_q        <= '0;
      hid_q         <= '0;
      hscore_q      <= '0;
      hguest_q      <= '0;
      ptr_q         <= '0;
      win_q         <= '0;
      grant_q       <= '0;
      rsp_valid_q   <= '0;
      rsp_pwin_q    <= 1'b0;
      rsp_gwin_q    <= 1'b0;
      trk_req_q     <= 1'b0;
      trk_id_q      <= '0;
      trk_score_q   <= '0;
      trk_guest_q   <= 1'b0;
`ifdef SCORE_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      hid_q         <= hid_d;
      hscore_q      <= hscore_d;
      hguest_q      <= hguest_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      grant_q       <= grant_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_pwin_q    <= rsp_pwin_d;
      rsp_gwin_q    <= rsp_gwin_d;
      trk_req_q     <= trk_req_d;
      trk_id_q      <= trk_id_d;
      trk_score_q   <= trk_score_d;
      trk_guest_q   <= trk_guest_d;
`ifdef SCORE_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign trk_req_o   = trk_req_q;
  assign trk_id_o    = trk_id_q;
  assign trk_score_o = trk_score_q;
  assign trk_guest_o = trk_guest_q;
  assign grant_o     = grant_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_pwin_o  = rsp_pwin_q;
  assign rsp_gwin_o  = rsp_gwin_q;
  assign busy_o      = (state_q != StIdle);

`ifdef SCORE_ARB_TIMEOUT_EN
  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

endmodule
